// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port SRAM arbiter.
// Imported by the arbiter top and its round-robin picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_t;

  typedef enum logic {
    PORT_C,
    PORT_L
  } arb_port_t;

  function automatic int cnt_width(input int wait_cycles);
    return $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU port, loader port and SRAM pins.
// master = arbiter side, slave = requesters and SRAM.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              C_req;
  logic              C_we;
  logic [ADDR_W-1:0] C_addr;
  logic [DATA_W-1:0] C_wdata;
  logic [DATA_W-1:0] C_rdata;
  logic              C_ack;
  logic              L_req;
  logic              L_we;
  logic [ADDR_W-1:0] L_addr;
  logic [DATA_W-1:0] L_wdata;
  logic [DATA_W-1:0] L_rdata;
  logic              L_ack;
  logic              Busy;
  logic              Grant_L;
  logic              CE_N;
  logic              OE_N;
  logic              WE_N;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Data_to_SRAM;
  logic              Data_oe;
  logic [DATA_W-1:0] Data_from_SRAM;

  modport master (
    input  C_req, C_we, C_addr, C_wdata,
    input  L_req, L_we, L_addr, L_wdata,
    input  Data_from_SRAM,
    output C_rdata, C_ack, L_rdata, L_ack,
    output Busy, Grant_L,
    output CE_N, OE_N, WE_N,
    output ADDR, Data_to_SRAM, Data_oe
  );

  modport slave (
    output C_req, C_we, C_addr, C_wdata,
    output L_req, L_we, L_addr, L_wdata,
    output Data_from_SRAM,
    input  C_rdata, C_ack, L_rdata, L_ack,
    input  Busy, Grant_L,
    input  CE_N, OE_N, WE_N,
    input  ADDR, Data_to_SRAM, Data_oe
  );

endinterface

// File: rtl/mem_port_arbiter_rr2.sv
// Two-input round-robin picker for the SRAM arbiter.
// Last-grant flop resets to L so C wins the first tie.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output arb_port_t  grant_o
);

  arb_port_t last_q;

  always_comb begin
    grant_o = PORT_C;
    unique case (1'b1)
      (req_i == 2'b10): grant_o = PORT_L;
      (req_i == 2'b11):
        grant_o = (last_q == PORT_C) ? PORT_L : PORT_C;
      default: grant_o = PORT_C;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PORT_L;
    end else if (upd_i) begin
      last_q <= grant_o;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and loader accesses onto one SRAM,
// running each as a fixed-length strobe cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 3
) (
  input logic          Clk,
  input logic          Reset_n,
  mem_port_arbiter_if.master bus
);

  localparam int CW = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  arb_state_t        state_q, state_d;
  arb_port_t         port_q, port_d, pick;
  logic              we_q, we_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] crd_q, crd_d;
  logic [DATA_W-1:0] lrd_q, lrd_d;
  logic              upd;
  logic [1:0]        req;
  logic              acc, dn;

  assign req = {bus.L_req, bus.C_req};

  mem_arb_rr2 u_rr (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .req_i   (req),
    .upd_i   (upd),
    .grant_o (pick)
  );

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    crd_d   = crd_q;
    lrd_d   = lrd_q;
    upd     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          upd     = 1'b1;
          port_d  = pick;
          cnt_d   = CNT_LOAD;
          state_d = ARB_ACCESS;
          if (pick == PORT_L) begin
            we_d    = bus.L_we;
            addr_d  = bus.L_addr;
            wdata_d = bus.L_wdata;
          end else begin
            we_d    = bus.C_we;
            addr_d  = bus.C_addr;
            wdata_d = bus.C_wdata;
          end
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ARB_DONE;
          if (!we_q) begin
            if (port_q == PORT_L) lrd_d = bus.Data_from_SRAM;
            else                  crd_d = bus.Data_from_SRAM;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ARB_IDLE;
      port_q  <= PORT_C;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      crd_q   <= '0;
      lrd_q   <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      crd_q   <= crd_d;
      lrd_q   <= lrd_d;
    end
  end

  // Strobes decode straight from state so reset kills them at once
  assign acc = (state_q == ARB_ACCESS);
  assign dn  = (state_q == ARB_DONE);

  assign bus.CE_N         = !acc;
  assign bus.OE_N         = !(acc && !we_q);
  assign bus.WE_N         = !(acc && we_q);
  assign bus.Data_oe      = acc && we_q;
  assign bus.C_ack        = dn && (port_q == PORT_C);
  assign bus.L_ack        = dn && (port_q == PORT_L);
  assign bus.Busy         = acc || dn;
  assign bus.Grant_L      = (port_q == PORT_L);
  assign bus.ADDR         = addr_q;
  assign bus.Data_to_SRAM = wdata_q;
  assign bus.C_rdata      = crd_q;
  assign bus.L_rdata      = lrd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps plus random
// traffic against a transaction-level timing model.
module tb_mem_port_arbiter;

  localparam int WC = 3;

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  always #5 Clk = ~Clk;

  mem_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();
  mem_port_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus1 ();

  mem_port_arbiter #(
    .ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(WC)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  mem_port_arbiter #(
    .ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(1)
  ) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus1)
  );

  function automatic logic [15:0] init_val(input int a);
    if (a == 'h10) return 16'h1234;
    return 16'(a * 40503 + 7);
  endfunction

  // SRAM device: written mid-cycle while WE_N is low
  logic [15:0] dev_mem [256];
  assign bus.Data_from_SRAM  = dev_mem[bus.ADDR[7:0]];
  assign bus1.Data_from_SRAM = dev_mem[bus1.ADDR[7:0]];

  initial begin
    for (int i = 0; i < 256; i++) dev_mem[i] = init_val(i);
    forever begin
      @(negedge Clk);
      if (bus.WE_N === 1'b0)
        dev_mem[bus.ADDR[7:0]] = bus.Data_to_SRAM;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: one in-flight transaction plus round-robin history
  int          k = 0;
  bit          cv;
  bit          cport;
  bit          cwe;
  logic [19:0] caddr;
  logic [15:0] cwd;
  int          cg;
  bit          last_l;
  int          next_ok;
  logic [15:0] exp_rd [2];
  logic [15:0] ref_mem [256];

  bit          req [2];
  bit          pwe [2];
  logic [19:0] paddr [2];
  logic [15:0] pwd [2];
  int          cnt_left [2];
  bit          granted [2];

  int oe_cnt = 0;
  int we_cnt = 0;
  int lack_cnt = 0;
  int ack_k = 0;
  int ack_q [$];

  function automatic bit ack_now(input int p);
    return cv && (k == cg + WC + 1) && (int'(cport) == p);
  endfunction

  task automatic model_reset();
    cv = 1'b0;
    last_l = 1'b1;
    next_ok = k;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic check_outputs();
    bit acc, dn;
    acc = cv && (k > cg) && (k <= cg + WC);
    dn  = cv && (k == cg + WC + 1);
    if (dn) begin
      if (cwe) ref_mem[caddr[7:0]] = cwd;
      else     exp_rd[cport] = ref_mem[caddr[7:0]];
    end
    chk("busy", bus.Busy, acc || dn);
    chk("ce_n", bus.CE_N, !acc);
    chk("oe_n", bus.OE_N, !(acc && !cwe));
    chk("we_n", bus.WE_N, !(acc && cwe));
    chk("data_oe", bus.Data_oe, acc && cwe);
    chk("c_ack", bus.C_ack, dn && !cport);
    chk("l_ack", bus.L_ack, dn && cport);
    chk("grant_l", bus.Grant_L, cv && cport);
    chk("addr", bus.ADDR, cv ? caddr : 20'h0);
    chk("wdata", bus.Data_to_SRAM, cv ? cwd : 16'h0);
    chk("c_rdata", bus.C_rdata, exp_rd[0]);
    chk("l_rdata", bus.L_rdata, exp_rd[1]);
    chk("we_oe_excl", !(!bus.WE_N && !bus.OE_N), 1);
    chk("two_acks", bus.C_ack && bus.L_ack, 0);
  endtask

  task automatic adv();
    @(posedge Clk);
    #1;
    k++;
    check_outputs();
    if (!bus.OE_N) oe_cnt++;
    if (!bus.WE_N && bus.Data_oe) we_cnt++;
    if (bus.C_ack) begin
      ack_q.push_back(0);
      ack_k = k;
    end
    if (bus.L_ack) begin
      ack_q.push_back(1);
      lack_cnt++;
      ack_k = k;
    end
  endtask

  task automatic model_grant();
    int w;
    if (Reset_n && k >= next_ok && (req[0] || req[1])) begin
      if (req[0] && req[1]) w = last_l ? 0 : 1;
      else                  w = req[0] ? 0 : 1;
      cv = 1'b1;
      cport = w[0];
      cwe = pwe[w];
      caddr = paddr[w];
      cwd = pwd[w];
      cg = k;
      last_l = w[0];
      next_ok = k + WC + 2;
      granted[w] = 1'b1;
    end
  endtask

  task automatic commit();
    bus.C_req = req[0];
    bus.C_we = pwe[0];
    bus.C_addr = paddr[0];
    bus.C_wdata = pwd[0];
    bus.L_req = req[1];
    bus.L_we = pwe[1];
    bus.L_addr = paddr[1];
    bus.L_wdata = pwd[1];
    model_grant();
  endtask

  task automatic set_port(input int p, input bit we,
                          input logic [19:0] a, input logic [15:0] d);
    req[p] = 1'b1;
    pwe[p] = we;
    paddr[p] = a;
    pwd[p] = d;
  endtask

  task automatic rnd_port(input int p);
    set_port(p, 1'($urandom_range(1, 0)), 20'($urandom), 16'($urandom));
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      adv();
      for (int p = 0; p < 2; p++) begin
        if (ack_now(p)) begin
          cnt_left[p]--;
          if (cnt_left[p] > 0) rnd_port(p);
          else req[p] = 1'b0;
        end
      end
      commit();
      done = !req[0] && !req[1] && (!cv || k >= cg + WC + 1);
    end
    chk(tag, done, 1);
  endtask

  initial begin
    int g;
    int l0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0;
      pwe[p] = 1'b0;
      paddr[p] = '0;
      pwd[p] = '0;
      cnt_left[p] = 0;
      granted[p] = 1'b0;
    end
    bus1.C_req = 1'b0; bus1.C_we = 1'b0;
    bus1.C_addr = '0; bus1.C_wdata = '0;
    bus1.L_req = 1'b0; bus1.L_we = 1'b0;
    bus1.L_addr = '0; bus1.L_wdata = '0;
    Reset_n = 1'b0;
    commit();
    model_reset();
    #1;
    check_outputs();
    repeat (2) adv();
    Reset_n = 1'b1;
    commit();

    // Reset in the middle of a C write
    adv();
    set_port(0, 1'b1, 20'h00040, ref_mem[8'h40]);
    commit();
    adv(); commit();
    adv(); commit();
    chk("t1_we_active", bus.WE_N, 0);
    #2;
    Reset_n = 1'b0;
    req[0] = 1'b0;
    commit();
    model_reset();
    #1;
    check_outputs();
    chk("t1_ce_n_reset", bus.CE_N, 1);
    chk("t1_oe_reset", bus.Data_oe, 0);
    adv();
    Reset_n = 1'b1;
    commit();
    repeat (6) begin
      adv();
      chk("t1_no_c_ack", bus.C_ack, 0);
      commit();
    end

    // C read of a preloaded word
    oe_cnt = 0;
    adv();
    set_port(0, 1'b0, 20'h00010, 16'h0);
    g = k;
    cnt_left[0] = 1;
    commit();
    wait_done(20, "t2_timeout");
    chk("t2_rdata", bus.C_rdata, 16'h1234);
    chk("t2_oe_cycles", oe_cnt, 3);
    chk("t2_ack_lat", ack_k - g, 4);

    // L write then C read back
    we_cnt = 0;
    l0 = lack_cnt;
    adv();
    set_port(1, 1'b1, 20'h00020, 16'hBEEF);
    cnt_left[1] = 1;
    commit();
    wait_done(20, "t3w_timeout");
    chk("t3_we_cycles", we_cnt, 3);
    chk("t3_l_acks", lack_cnt - l0, 1);
    adv();
    set_port(0, 1'b0, 20'h00020, 16'h0);
    cnt_left[0] = 1;
    commit();
    wait_done(20, "t3r_timeout");
    chk("t3_rdata", bus.C_rdata, 16'hBEEF);

    // Both ports together after reset alternate from C
    adv();
    Reset_n = 1'b0;
    commit();
    model_reset();
    adv();
    Reset_n = 1'b1;
    commit();
    ack_q.delete();
    adv();
    rnd_port(0);
    rnd_port(1);
    cnt_left[0] = 4;
    cnt_left[1] = 4;
    commit();
    wait_done(100, "t4_timeout");
    chk("t4_acks", ack_q.size(), 8);
    for (int i = 0; i < ack_q.size() && i < 8; i++)
      chk($sformatf("t4_order%0d", i), ack_q[i], i % 2);

    // Short L pulse while C is busy
    l0 = lack_cnt;
    adv();
    set_port(0, 1'b0, 20'h00055, 16'h0);
    cnt_left[0] = 1;
    commit();
    adv(); commit();
    adv(); rnd_port(1); commit();
    adv(); req[1] = 1'b0; commit();
    wait_done(20, "t5_timeout");
    repeat (3) begin adv(); commit(); end
    chk("t5_no_l_ack", lack_cnt - l0, 0);

    // Random traffic
    granted[0] = 1'b0;
    granted[1] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      adv();
      for (int p = 0; p < 2; p++) begin
        if (ack_now(p)) begin
          granted[p] = 1'b0;
          if ($urandom_range(1, 0) == 1) rnd_port(p);
          else req[p] = 1'b0;
        end else if (granted[p]) begin
          if ($urandom_range(9, 0) == 0) req[p] = 1'b0;
        end else if (!req[p]) begin
          if ($urandom_range(3, 0) == 0) rnd_port(p);
        end else if ($urandom_range(9, 0) == 0) begin
          req[p] = 1'b0;
        end
      end
      commit();
    end
    cnt_left[0] = 0;
    cnt_left[1] = 0;
    wait_done(60, "drain_timeout");

    // Single-cycle access build
    adv();
    bus1.C_req = 1'b1;
    bus1.C_we = 1'b0;
    bus1.C_addr = 20'h00030;
    commit();
    adv();
    chk("t6_oe", bus1.OE_N, 0);
    chk("t6_busy", bus1.Busy, 1);
    chk("t6_noack", bus1.C_ack, 0);
    commit();
    adv();
    chk("t6_ack", bus1.C_ack, 1);
    chk("t6_oe_off", bus1.OE_N, 1);
    chk("t6_rdata", bus1.C_rdata, ref_mem[8'h30]);
    bus1.C_req = 1'b0;
    commit();
    adv();
    chk("t6_idle", bus1.Busy, 0);
    chk("t6_one_ack", bus1.C_ack, 0);
    commit();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
